// File: rtl/key_pulse_generator_pkg.sv
// Shared types and constants for the key pulse generator and its digit counter.
package key_pulse_generator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StFin
  } state_e;

  localparam logic [3:0] BcdMax = 4'd9;
  localparam int unsigned DefaultHighCycles = 4;
  localparam int unsigned DefaultLowCycles  = 4;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BcdMax) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/key_pulse_generator_if.sv
// Board-facing signal bundle: start key and count switches in, pulse train and status out.
interface key_pulse_generator_if;

  logic       KEY_1;
  logic [3:0] SW;
  logic       PULSE;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic       W;
  logic       X;
  logic       Y;
  logic       Z;

  modport master (
    output KEY_1, SW,
    input  PULSE, BUSY, DONE, ERR, W, X, Y, Z
  );

  modport slave (
    input  KEY_1, SW,
    output PULSE, BUSY, DONE, ERR, W, X, Y, Z
  );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer and falling-edge detector for an active-low push button.
module key_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic fall_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] fill_q;

  // Edges only count once the key has been seen released with real post-reset samples,
  // so a key held through reset cannot fire a start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign fall_o = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/key_pulse_generator.sv
// Emits a burst of SW key pulses on a button press and tracks the receiver's expected digit.
module key_pulse_generator
  import key_pulse_generator_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DefaultHighCycles,
  parameter int unsigned LOW_CYCLES  = DefaultLowCycles
) (
  input logic                  PIN_Y2,
  input logic                  KEY_0,
  key_pulse_generator_if.slave bus
);

  localparam int unsigned MaxCycles = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [TimerW-1:0] HighLoad = TimerW'(HIGH_CYCLES - 1);
  localparam logic [TimerW-1:0] LowLoad  = TimerW'(LOW_CYCLES - 1);

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [3:0]        rem_q;
  logic [3:0]        digit_q;
  logic              pulse_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              start;
  logic [3:0]        rem_dec;

  key_sync u_key_sync (
    .clk_i  (PIN_Y2),
    .rst_ni (KEY_0),
    .key_ni (bus.KEY_1),
    .fall_o (start)
  );

  assign rem_dec = rem_q - 4'd1;

  always_ff @(posedge PIN_Y2 or negedge KEY_0) begin
    if (!KEY_0) begin
      state_q <= StIdle;
      timer_q <= '0;
      rem_q   <= 4'd0;
      digit_q <= 4'd0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (bus.SW > BcdMax) begin
              err_q <= 1'b1;
            end else begin
              err_q  <= 1'b0;
              rem_q  <= bus.SW;
              busy_q <= 1'b1;
              if (bus.SW != 4'd0) begin
                state_q <= StHigh;
                pulse_q <= 1'b1;
                timer_q <= HighLoad;
              end else begin
                state_q <= StFin;
                done_q  <= 1'b1;
                timer_q <= '0;
              end
            end
          end
        end
        StHigh: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TimerW'(1);
          end else begin
            pulse_q <= 1'b0;
            rem_q   <= rem_dec;
            digit_q <= bcd_inc(digit_q);
            if (rem_dec != 4'd0) begin
              state_q <= StLow;
              timer_q <= LowLoad;
            end else begin
              state_q <= StFin;
              done_q  <= 1'b1;
              timer_q <= '0;
            end
          end
        end
        StLow: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TimerW'(1);
          end else begin
            state_q <= StHigh;
            pulse_q <= 1'b1;
            timer_q <= HighLoad;
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          timer_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.PULSE = pulse_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;
  assign {bus.W, bus.X, bus.Y, bus.Z} = digit_q;

endmodule
